// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants for the EX hazard controller
// Purpose: forward-select encoding, FSM state encoding and the bit layout of a
// shadow-pipe entry {valid, reg_write, is_load, rd}.
// Ports: none (package).
package hazard_pkg;

    // Operand source selects driven to the EX forward muxes
    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // Controller state: cause of the control applied in a cycle
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Shadow entry is REG_ADDR_W+3 bits wide; these are bit offsets above rd
    localparam int ENT_VALID_OFS = 2;
    localparam int ENT_WR_OFS    = 1;
    localparam int ENT_LD_OFS    = 0;

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// rtl/ex_hazard_ctrl_if.sv - ID-side request and EX control bundle
// Purpose: groups the decode-stage hazard inputs and the forwarding/stall
// outputs of ex_hazard_ctrl.
// Modports: master = pipeline side (drives id_*, ex_branch_taken, mem_busy);
//           slave  = hazard controller (drives fwd_*_sel, stall/bubble/flush,
//           freeze, stall_cnt).
interface ex_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_is_load;
    logic                  ex_branch_taken;
    logic                  mem_busy;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic                  stall_pc_id;
    logic                  bubble_ex;
    logic                  flush_if_id;
    logic                  freeze;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_reg_write, id_is_load, ex_branch_taken, mem_busy,
        input  fwd_a_sel, fwd_b_sel, stall_pc_id, bubble_ex, flush_if_id,
               freeze, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_reg_write, id_is_load, ex_branch_taken, mem_busy,
        output fwd_a_sel, fwd_b_sel, stall_pc_id, bubble_ex, flush_if_id,
               freeze, stall_cnt
    );
endinterface

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - one source register vs one shadow-pipe entry
// Purpose: flags a RAW dependency of an ID source on a younger writer.
// Ports: rs_i (source index), rs_used_i (source is read), entry_i (shadow
// entry {valid, reg_write, is_load, rd}), hit_o (dependency present).
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic                  rs_used_i,
    input  logic [REG_ADDR_W+2:0] entry_i,
    output logic                  hit_o
);
    // x0 is hard-wired zero, so it never carries a dependency
    assign hit_o = rs_used_i
                && (rs_i != '0)
                && entry_i[REG_ADDR_W+ENT_VALID_OFS]
                && entry_i[REG_ADDR_W+ENT_WR_OFS]
                && (rs_i == entry_i[REG_ADDR_W-1:0]);

    // Load flag is interpreted by the caller, not here
    logic unused_ld;
    assign unused_ld = entry_i[REG_ADDR_W+ENT_LD_OFS];
endmodule

// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - EX-stage forwarding, stall, bubble and flush control
// Purpose: tracks destination info for EX/MEM/WB in a shadow pipe and derives
// operand-forward selects, RAW/load-use stalls, EX bubbles and branch flushes.
// Ports: clk, rst_n (async active-low), hz (ex_hazard_ctrl_if.slave).
// Config: EX_FORWARD_EN defined -> EX/MEM and MEM/WB forwarding, load-use
// stall only; undefined -> selects tied to FWD_REG, ID stalls on any match.
module ex_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ex_hazard_ctrl_if.slave  hz
);
    localparam int EW = REG_ADDR_W + 3;

    logic [EW-1:0]    ex_q, mem_q, wb_q, ex_d;
    logic [1:0]       fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;

    logic             id_live, rs1_used, rs2_used;
    logic             branch, raw_stall, stall, bubble;
    logic [2:0]       hit_a, hit_b;
    logic [EW-1:0]    stage_ent [3];

    // The cycle after a flush, IF/ID has been squashed: ignore whatever ID shows
    assign id_live  = hz.id_valid && (state_q != ST_FLUSH);
    assign rs1_used = id_live && hz.id_rs1_used;
    assign rs2_used = id_live && hz.id_rs2_used;

    assign stage_ent[0] = ex_q;
    assign stage_ent[1] = mem_q;
    assign stage_ent[2] = wb_q;

    for (genvar g = 0; g < 3; g++) begin : g_match
        hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_a (
            .rs_i      (hz.id_rs1),
            .rs_used_i (rs1_used),
            .entry_i   (stage_ent[g]),
            .hit_o     (hit_a[g])
        );
        hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_b (
            .rs_i      (hz.id_rs2),
            .rs_used_i (rs2_used),
            .entry_i   (stage_ent[g]),
            .hit_o     (hit_b[g])
        );
    end

    assign branch = hz.ex_branch_taken && ex_q[REG_ADDR_W+ENT_VALID_OFS];

`ifdef EX_FORWARD_EN
    // Load data is not ready until MEM, so a load in EX cannot be forwarded yet
    assign raw_stall = ex_q[REG_ADDR_W+ENT_LD_OFS] && (hit_a[0] || hit_b[0]);

    // A WB-stage writer has retired by the time ID reaches EX
    logic unused_wb_hit;
    assign unused_wb_hit = hit_a[2] | hit_b[2];
`else
    assign raw_stall = (|hit_a) || (|hit_b);
`endif

    // A taken branch squashes the ID instruction, so its stall is moot
    assign stall  = raw_stall && !branch;
    assign bubble = stall || branch;

    always_comb begin
        ex_d    = bubble ? '0 : {id_live, hz.id_reg_write, hz.id_is_load, hz.id_rd};
        fwd_a_d = FWD_REG;
        fwd_b_d = FWD_REG;
`ifdef EX_FORWARD_EN
        // Selects follow the instruction into EX; a bubble carries no operands
        if (!bubble) begin
            if (hit_a[0])      fwd_a_d = FWD_EX;
            else if (hit_a[1]) fwd_a_d = FWD_WB;
            if (hit_b[0])      fwd_b_d = FWD_EX;
            else if (hit_b[1]) fwd_b_d = FWD_WB;
        end
`endif
        if (branch)     state_d = ST_FLUSH;
        else if (stall) state_d = ST_STALL;
        else            state_d = ST_RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_REG;
            fwd_b_q <= FWD_REG;
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else if (!hz.mem_busy) begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            state_q <= state_d;
            if (stall && (cnt_q != '1)) begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign hz.fwd_a_sel   = fwd_a_q;
    assign hz.fwd_b_sel   = fwd_b_q;
    assign hz.stall_pc_id = stall;
    assign hz.bubble_ex   = bubble;
    assign hz.flush_if_id = branch;
    assign hz.freeze      = hz.mem_busy;
    assign hz.stall_cnt   = cnt_q;
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb/tb_ex_hazard_ctrl.sv - directed self-checking bench for ex_hazard_ctrl
module tb_ex_hazard_ctrl;

`ifdef EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    // Stall count accumulated by the mode-specific RAW steps
    localparam int C0 = FWD ? 1 : 3;

    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    ex_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) hz ();

    ex_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    task automatic set_id(input int v, input int rs1, input int u1, input int rs2,
                          input int u2, input int rd, input int wr, input int ld);
        hz.id_valid     = 1'(v);
        hz.id_rs1       = 5'(rs1);
        hz.id_rs1_used  = 1'(u1);
        hz.id_rs2       = 5'(rs2);
        hz.id_rs2_used  = 1'(u2);
        hz.id_rd        = 5'(rd);
        hz.id_reg_write = 1'(wr);
        hz.id_is_load   = 1'(ld);
    endtask

    task automatic nop_id();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Layout: {fwd_a, fwd_b, stall, bubble, flush, freeze, stall_cnt}
    task automatic chk(input string tag, input int fa, input int fb, input int st,
                       input int bub, input int fl, input int frz, input int cnt);
        logic [23:0] obs, exp;
        #1;
        obs = {hz.fwd_a_sel, hz.fwd_b_sel, hz.stall_pc_id, hz.bubble_ex,
               hz.flush_if_id, hz.freeze, hz.stall_cnt};
        exp = {2'(fa), 2'(fb), 1'(st), 1'(bub), 1'(fl), 1'(frz), 16'(cnt)};
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h need %h (fa,fb,st,bub,fl,frz,cnt)", tag, obs, exp);
    endtask

    task automatic drain();
        nop_id();
        repeat (3) tick();
    endtask

    initial begin
        rst_n              = 1'b0;
        hz.mem_busy        = 1'b0;
        hz.ex_branch_taken = 1'b0;
        nop_id();
        repeat (2) @(posedge clk);
        #2;
        chk("reset", 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Writer of x0, then reader of x0; then unused sources naming a live rd
        set_id(1, 1, 1, 2, 1, 0, 1, 0);  chk("x0_writer", 0, 0, 0, 0, 0, 0, 0); tick();
        set_id(1, 0, 1, 0, 1, 7, 1, 0);  chk("x0_reader", 0, 0, 0, 0, 0, 0, 0); tick();
        nop_id();                        chk("x0_reader_ex", 0, 0, 0, 0, 0, 0, 0); tick();
        set_id(1, 7, 0, 7, 0, 8, 1, 0);  chk("rs_unused", 0, 0, 0, 0, 0, 0, 0);
        drain();

        // Taken branch in EX while ID has a load-use hit: flush wins
        set_id(1, 1, 1, 0, 0, 5, 1, 1);  chk("br_lw", 0, 0, 0, 0, 0, 0, 0); tick();
        set_id(1, 5, 1, 1, 1, 6, 1, 0);
        hz.ex_branch_taken = 1'b1;       chk("br_flush", 0, 0, 0, 1, 1, 0, 0); tick();
        nop_id();                        chk("br_ex_invalid", 0, 0, 0, 0, 0, 0, 0); tick();
        hz.ex_branch_taken = 1'b0;
        drain();

`ifdef EX_FORWARD_EN
        // add x5,x1,x2 ; sub x6,x5,x3 -> EX/MEM forward on A
        set_id(1, 1, 1, 2, 1, 5, 1, 0);  chk("fwd_add", 0, 0, 0, 0, 0, 0, 0); tick();
        set_id(1, 5, 1, 3, 1, 6, 1, 0);  chk("fwd_sub_id", 0, 0, 0, 0, 0, 0, 0); tick();
        nop_id();                        chk("fwd_ex", 1, 0, 0, 0, 0, 0, 0);
        drain();
        // add x5 ; nop ; or x7,x5,x5 -> MEM/WB forward on both
        set_id(1, 1, 1, 2, 1, 5, 1, 0);  chk("wb_add", 0, 0, 0, 0, 0, 0, 0); tick();
        nop_id();                        chk("wb_nop", 0, 0, 0, 0, 0, 0, 0); tick();
        set_id(1, 5, 1, 5, 1, 7, 1, 0);  chk("wb_or_id", 0, 0, 0, 0, 0, 0, 0); tick();
        nop_id();                        chk("wb_ex", 2, 2, 0, 0, 0, 0, 0);
        drain();
        // lw x5 ; add x6,x5,x1 -> one stall, then forward from WB
        set_id(1, 1, 1, 0, 0, 5, 1, 1);  chk("lu_lw", 0, 0, 0, 0, 0, 0, 0); tick();
        set_id(1, 5, 1, 1, 1, 6, 1, 0);  chk("lu_stall", 0, 0, 1, 1, 0, 0, 0); tick();
        chk("lu_release", 0, 0, 0, 0, 0, 0, 1); tick();
        nop_id();                        chk("lu_fwd", 2, 0, 0, 0, 0, 0, 1);
        drain();
`else
        // add x5,x1,x2 ; add x6,x5,x3 -> stalls until the writer leaves WB
        set_id(1, 1, 1, 2, 1, 5, 1, 0);  chk("raw_add", 0, 0, 0, 0, 0, 0, 0); tick();
        set_id(1, 5, 1, 3, 1, 6, 1, 0);  chk("raw_ex", 0, 0, 1, 1, 0, 0, 0); tick();
        chk("raw_mem", 0, 0, 1, 1, 0, 0, 1); tick();
        chk("raw_wb", 0, 0, 1, 1, 0, 0, 2); tick();
        chk("raw_go", 0, 0, 0, 0, 0, 0, 3); tick();
        nop_id();                        chk("raw_sel", 0, 0, 0, 0, 0, 0, 3);
        drain();
`endif

        // Load-use stall frozen by mem_busy for 3 cycles, then reset mid-stall
        set_id(1, 1, 1, 0, 0, 5, 1, 1);  chk("busy_lw", 0, 0, 0, 0, 0, 0, C0); tick();
        set_id(1, 5, 1, 1, 1, 6, 1, 0);
        hz.mem_busy = 1'b1;              chk("busy_stall", 0, 0, 1, 1, 0, 1, C0);
        repeat (2) begin
            tick();
            chk("busy_hold", 0, 0, 1, 1, 0, 1, C0);
        end
        tick();
        hz.mem_busy = 1'b0;              chk("busy_release", 0, 0, 1, 1, 0, 0, C0); tick();
        chk("busy_after", 0, 0, FWD ? 0 : 1, FWD ? 0 : 1, 0, 0, C0 + 1);
        rst_n = 1'b0;                    chk("reset_mid", 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
